// File: rtl/core_sequencer_if.sv
// core_sequencer_if: enable/completed handshake bundle between the sequencer and its stages.
interface core_sequencer_if;
    logic fetch_enabled, decode_enabled, exec_enabled, mem_enabled, wb_enabled;
    logic fetch_completed, decode_completed, exec_completed, mem_completed, wb_completed;
    logic need_mem;
    logic exec_is_jump_chosen;
    logic [31:0] exec_jump_dest;
    modport master (
        output fetch_enabled, decode_enabled, exec_enabled, mem_enabled, wb_enabled,
        input fetch_completed, decode_completed, exec_completed, mem_completed, wb_completed,
        input need_mem, exec_is_jump_chosen, exec_jump_dest
    );
    modport slave (
        input fetch_enabled, decode_enabled, exec_enabled, mem_enabled, wb_enabled,
        output fetch_completed, decode_completed, exec_completed, mem_completed, wb_completed,
        output need_mem, exec_is_jump_chosen, exec_jump_dest
    );
endinterface

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/exec/mem/wb control FSM with PC, retire count, halt, watchdog and jump trap.
module core_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [31:0]             start_pc,
    input  logic                    halt_req,
    core_sequencer_if.master        stg,
    output logic [31:0]             pc,
    output logic                    busy,
    output logic                    halted,
    output logic                    error,
    output logic [1:0]              err_cause,
    output logic [31:0]             retired_count
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED, ERROR} state_t;
    localparam logic [15:0] TMO = 16'(TIMEOUT);
    state_t state;
    logic issue, mem_path, halt_pending, done, misaligned;
    logic [15:0] wd;
    logic [31:0] next_pc, jump_pc;
    logic [4:0] en;
    always_comb begin
        done = state == FETCH  ? stg.fetch_completed  :
               state == DECODE ? stg.decode_completed :
               state == EXEC   ? stg.exec_completed   :
               state == MEM    ? stg.mem_completed    :
               state == WB     ? stg.wb_completed     : 1'b0;
    end
    assign misaligned = stg.exec_is_jump_chosen && stg.exec_jump_dest[1:0] != 2'b00;
    assign jump_pc = stg.exec_is_jump_chosen ? stg.exec_jump_dest : pc + 32'd4;
    assign {stg.wb_enabled, stg.mem_enabled, stg.exec_enabled, stg.decode_enabled, stg.fetch_enabled} = en;
    assign busy = state inside {FETCH, DECODE, EXEC, MEM, WB};
    assign halted = state == HALTED;
    assign error = state == ERROR;
    // en is one-hot and only high in the ISSUE cycle; it is loaded on the edge that enters a stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            issue <= 1'b0;
            en <= '0;
            pc <= RESET_PC;
            next_pc <= RESET_PC;
            retired_count <= '0;
            err_cause <= 2'd0;
            halt_pending <= 1'b0;
            mem_path <= 1'b0;
            wd <= '0;
        end else begin
            en <= '0;
            issue <= 1'b0;
            if (halt_req && busy) halt_pending <= 1'b1;
            if (issue) wd <= '0;
            else if (busy && !done) wd <= wd + 16'd1;
            if ((state == IDLE || state == HALTED) && start) begin
                pc <= start_pc;
                state <= FETCH;
                issue <= 1'b1;
                en <= 5'b00001;
            end else if (busy && !issue && done) begin
                issue <= 1'b1;
                case (state)
                    FETCH: begin
                        state <= DECODE;
                        en <= 5'b00010;
                    end
                    DECODE: begin
                        mem_path <= stg.need_mem;
                        state <= EXEC;
                        en <= 5'b00100;
                    end
                    EXEC: begin
                        if (misaligned) begin
                            state <= ERROR;
                            err_cause <= 2'd2;
                            issue <= 1'b0;
                        end else begin
                            next_pc <= jump_pc;
                            state <= mem_path ? MEM : WB;
                            en <= mem_path ? 5'b01000 : 5'b10000;
                        end
                    end
                    MEM: begin
                        state <= WB;
                        en <= 5'b10000;
                    end
                    default: begin
                        pc <= next_pc;
                        retired_count <= retired_count + 32'd1;
                        if (halt_pending || halt_req) begin
                            state <= HALTED;
                            halt_pending <= 1'b0;
                            issue <= 1'b0;
                        end else begin
                            state <= FETCH;
                            en <= 5'b00001;
                        end
                    end
                endcase
            end else if (busy && !issue && TMO != 16'd0 && wd + 16'd1 == TMO) begin
                state <= ERROR;
                err_cause <= 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: random and directed stimulus checked every cycle against a stage-route queue model.
module tb_core_sequencer;
    localparam int TMO = 4;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, halt_req = 1'b0;
    logic [31:0] start_pc = '0;
    logic [4:0] comp = '0;
    logic need_mem = 1'b0, jmp = 1'b0;
    logic [31:0] dest = '0;
    logic [31:0] pc, retired_count;
    logic busy, halted, error;
    logic [1:0] err_cause;
    logic [4:0] en;
    core_sequencer_if ifc();
    core_sequencer #(.RESET_PC(32'h0), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .start_pc(start_pc), .halt_req(halt_req), .stg(ifc),
        .pc(pc), .busy(busy), .halted(halted), .error(error), .err_cause(err_cause), .retired_count(retired_count)
    );
    assign {ifc.wb_completed, ifc.mem_completed, ifc.exec_completed, ifc.decode_completed, ifc.fetch_completed} = comp;
    assign ifc.need_mem = need_mem;
    assign ifc.exec_is_jump_chosen = jmp;
    assign ifc.exec_jump_dest = dest;
    assign en = {ifc.wb_enabled, ifc.mem_enabled, ifc.exec_enabled, ifc.decode_enabled, ifc.fetch_enabled};
    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    bit chk_on = 0;
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 running, 2 halted, 3 error; route lists remaining stages (0 F,1 D,2 E,3 M,4 W)
    int mode = 0, age = 0, cur;
    int route[$];
    logic [31:0] m_pc = '0, m_npc = '0, m_ret = '0;
    bit hp = 0;
    logic [1:0] m_cause = '0;
    always @(posedge clk) begin
        if (rst) begin
            mode = 0; route = {}; age = 0; m_pc = '0; m_npc = '0; m_ret = '0; hp = 0; m_cause = '0;
        end else if (mode == 0 || mode == 2) begin
            if (start) begin m_pc = start_pc; mode = 1; route = {0, 1, 2, 4}; age = 0; end
        end else if (mode == 1) begin
            cur = route[0];
            if (halt_req) hp = 1;
            if (age == 0) age = 1;
            else if (comp[cur]) begin
                age = 0;
                void'(route.pop_front());
                if (cur == 1 && need_mem) route.insert(1, 3);
                if (cur == 2) begin
                    if (jmp && dest[1:0] != 2'b00) begin mode = 3; m_cause = 2; end
                    else m_npc = jmp ? dest : m_pc + 32'd4;
                end
                if (cur == 4) begin
                    m_pc = m_npc; m_ret = m_ret + 1;
                    if (hp) begin mode = 2; hp = 0; end else route = {0, 1, 2, 4};
                end
            end else if (age == TMO) begin mode = 3; m_cause = 1; end
            else age++;
        end
    end

    // Knobs for the stage responder, written only by the main sequence
    bit manual = 0, rnd = 0, spur = 0, late_ok = 0, d_need = 0, d_jmp = 0;
    logic [31:0] d_dest = '0;
    logic [4:0] m_comp = '0;
    int dmax = 0, stall = -1, target = 0, seen = 0;
    logic [4:0] exp_en;
    always @(negedge clk) begin
        if (chk_on) begin
            exp_en = (mode == 1 && age == 0) ? 5'(1 << route[0]) : 5'b0;
            cmp("enables", 32'(en), 32'(exp_en));
            cmp("status", {27'd0, busy, halted, error, err_cause}, {27'd0, mode == 1, mode == 2, mode == 3, m_cause});
            cmp("pc", pc, m_pc);
            cmp("retired", retired_count, m_ret);
        end
        if (!rnd) begin need_mem = d_need; jmp = d_jmp; dest = d_dest; end
        if (manual) comp = m_comp;
        else begin
            comp = '0;
            if (mode == 1) begin
                if (age == 0) begin
                    target = (late_ok && $urandom_range(0, 15) == 0) ? TMO : $urandom_range(0, dmax);
                    seen = 0;
                    if (rnd && route[0] == 0) begin
                        need_mem = 1'($urandom_range(0, 1));
                        jmp = $urandom_range(0, 2) == 0;
                        dest = 32'($urandom) & ~32'h3;
                        if ($urandom_range(0, 15) == 0) dest[1:0] = 2'($urandom_range(1, 3));
                    end
                end else begin
                    seen++;
                    if (route[0] != stall && seen == target + 1) comp[route[0]] = 1'b1;
                end
            end
            if (spur)
                for (int k = 0; k < 5; k++)
                    if ($urandom_range(0, 3) == 0 && !(mode == 1 && age != 0 && k == route[0])) comp[k] = 1'b1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask
    // sel: 0 fetch_enabled or idle, 1 exec_enabled, 2 decode_enabled, 3 error, 4 not busy
    task automatic run_until(input int sel, output int n, output int mems, output int wbs);
        bit hit;
        n = 0; mems = 0; wbs = 0; hit = 0;
        while (!hit && n < 200) begin
            tick();
            n++;
            if (en[3]) mems++;
            if (en[4]) wbs++;
            hit = sel == 0 ? (en[0] || !busy) : sel == 1 ? en[2] : sel == 2 ? en[1] : sel == 3 ? error : !busy;
        end
        cmp("wait_bound", 32'(hit), 32'd1);
    endtask

    int n, mems, wbs, fetches;
    initial begin
        tick(); tick();
        rst = 1'b0;
        chk_on = 1;
        cmp("reset_pc", pc, 32'h0);
        cmp("reset_retired", retired_count, 32'h0);
        cmp("reset_flags", {27'd0, busy, halted, error, err_cause}, 32'h0);
        // straight-line, single-cycle stage latency
        start = 1'b1; start_pc = 32'h100;
        tick();
        start = 1'b0;
        cmp("first_fetch_en", 32'(en), 32'h1);
        cmp("first_pc", pc, 32'h100);
        for (int i = 1; i <= 3; i++) begin
            run_until(0, n, mems, wbs);
            cmp("insn_cycles", n, 32'd8);
            cmp("seq_pc", pc, 32'h100 + 32'(4 * i));
            cmp("seq_retired", retired_count, 32'(i));
        end
        // memory path plus aligned jump
        d_need = 1'b1; d_jmp = 1'b1; d_dest = 32'h200;
        run_until(0, n, mems, wbs);
        cmp("mem_insn_cycles", n, 32'd10);
        cmp("mem_en_count", mems, 32'd1);
        cmp("jump_pc", pc, 32'h200);
        cmp("jump_retired", retired_count, 32'd4);
        // halt during EXEC, then restart
        d_need = 1'b0; d_jmp = 1'b0;
        run_until(1, n, mems, wbs);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        run_until(4, n, mems, wbs);
        cmp("halted", 32'(halted), 32'd1);
        cmp("halt_retired", retired_count, 32'd5);
        cmp("halt_pc", pc, 32'h204);
        fetches = 0;
        repeat (20) begin tick(); if (en[0]) fetches++; end
        cmp("halt_no_fetch", fetches, 32'd0);
        start = 1'b1; start_pc = 32'h40;
        tick();
        start = 1'b0;
        cmp("restart_fetch_en", 32'(en), 32'h1);
        cmp("restart_pc", pc, 32'h40);
        // watchdog on a missing decode_completed
        stall = 1;
        run_until(2, n, mems, wbs);
        repeat (4) tick();
        cmp("wd_not_yet", 32'(error), 32'd0);
        tick();
        cmp("wd_error", 32'(error), 32'd1);
        cmp("wd_cause", 32'(err_cause), 32'd1);
        manual = 1; m_comp = 5'b00010; start = 1'b1; start_pc = 32'h80;
        tick();
        m_comp = '0; start = 1'b0;
        tick();
        manual = 0; stall = -1;
        cmp("wd_sticky", {27'd0, busy, halted, error, err_cause}, {27'd0, 3'b001, 2'd1});
        cmp("wd_pc", pc, 32'h40);
        // misaligned jump trap
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp("rst_from_error", {27'd0, busy, halted, error, err_cause}, 32'h0);
        d_need = 1'b1; d_jmp = 1'b1; d_dest = 32'h202;
        start = 1'b1; start_pc = 32'h300;
        tick();
        start = 1'b0;
        run_until(3, n, mems, wbs);
        cmp("mis_cycles", n, 32'd6);
        cmp("mis_no_mem_wb", mems + wbs, 32'd0);
        cmp("mis_cause", 32'(err_cause), 32'd2);
        cmp("mis_pc", pc, 32'h300);
        cmp("mis_retired", retired_count, 32'd0);
        // reset while waiting in EXEC, then a stale exec_completed
        rst = 1'b1;
        tick();
        rst = 1'b0; d_need = 1'b0; d_jmp = 1'b0;
        start = 1'b1; start_pc = 32'h500;
        tick();
        start = 1'b0;
        run_until(1, n, mems, wbs);
        manual = 1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp("midrst_en", 32'(en), 32'h0);
        cmp("midrst_pc", pc, 32'h0);
        m_comp = 5'b00100;
        tick();
        m_comp = '0;
        tick();
        manual = 0;
        cmp("stale_exec", {27'd0, busy, halted, error, err_cause}, 32'h0);
        cmp("stale_pc", pc, 32'h0);
        // randomized traffic: jitter, late completions, spurious pulses, halts, restarts, resets
        rnd = 1; spur = 1; late_ok = 1; dmax = 3;
        repeat (4000) begin
            tick();
            rst = (mode == 3 && $urandom_range(0, 3) == 0) || $urandom_range(0, 999) == 0;
            start = $urandom_range(0, 5) == 0;
            start_pc = $urandom_range(0, 7) == 0 ? 32'hFFFF_FFFC : 32'($urandom) & ~32'h3;
            halt_req = $urandom_range(0, 19) == 0;
        end
        tick();
        chk_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM for the non-pipelined core. It steps one instruction at a time through fetch, decode, execute, optional memory and write-back, using each stage's enabled/completed handshake. It owns the architectural PC and applies the execute stage's branch decision. It also counts retired instructions and supports halt/restart, a per-stage watchdog and a misaligned-jump trap.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset
- TIMEOUT, 1024, max WAIT cycles per stage before ERROR; 0 disables the watchdog; legal range 0..65535
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  pulse; in IDLE or HALTED loads pc <= start_pc and begins FETCH; ignored in other states
- start_pc  in  32  restart address
- halt_req  in  1  request to stop after the current instruction retires
- fetch_enabled / decode_enabled / exec_enabled / mem_enabled / wb_enabled  out  1 each  one-cycle stage start pulses
- fetch_completed / decode_completed / exec_completed / mem_completed / wb_completed  in  1 each  stage done pulses
- need_mem  in  1  from decode, valid when decode_completed=1; 1 = instruction uses the MEM stage
- exec_is_jump_chosen  in  1  valid with exec_completed
- exec_jump_dest  in  32  valid with exec_completed
- pc  out  32  PC of the instruction in flight; driven to all stages
- busy  out  1  state is not IDLE, HALTED or ERROR
- halted  out  1  state == HALTED
- error  out  1  state == ERROR
- err_cause  out  2  0 none, 1 watchdog, 2 misaligned jump
- retired_count  out  32  instructions retired; wraps at 2^32

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED, ERROR.
- Each stage state has two phases:
  - ISSUE (first cycle): the matching *_enabled = 1. Completed inputs are ignored in this cycle.
  - WAIT: enable = 0; the FSM waits for the matching *_completed.
- Only one enable is ever high at a time. Completed pulses from stages other than the current one are ignored.
- Transitions (taken on the edge after completed is sampled in WAIT):
  - FETCH→DECODE; DECODE→MEM-path flag latched from need_mem, then →EXEC.
  - EXEC→MEM if the flag is set, else →WB; MEM→WB.
  - WB→FETCH, or →HALTED if halt_pending.
- On exec_completed:
  - next_pc <= exec_is_jump_chosen ? exec_jump_dest : pc + 4, with 32-bit wrap.
  - If exec_is_jump_chosen and exec_jump_dest[1:0] != 0: go to ERROR with err_cause = 2, next_pc unchanged.
- On wb_completed: pc <= next_pc and retired_count += 1.
- halt_pending:
  - Set whenever halt_req = 1 while busy; cleared on entry to HALTED.
  - halt_req in IDLE or HALTED is ignored.
- Watchdog:
  - 16-bit counter cleared in ISSUE, incremented each WAIT cycle without completed.
  - When the count reaches TIMEOUT (TIMEOUT ≠ 0): go to ERROR with err_cause = 1.
- ERROR is sticky; only rst leaves it. start is ignored in ERROR.
- Reset (any state, including mid-stage): next cycle state = IDLE, all enables 0, pc = RESET_PC, next_pc = RESET_PC, retired_count = 0, busy = halted = error = 0, err_cause = 0, halt_pending = 0, watchdog = 0.

## Timing
- start sampled at edge E → state FETCH/ISSUE in the cycle after E, fetch_enabled = 1 that cycle, pc = start_pc.
- Minimum per stage: 2 cycles (ISSUE, then completed in the first WAIT cycle).
- Minimum per instruction: 8 cycles without MEM, 10 with MEM.
- The next stage's enable is asserted in the cycle immediately after its predecessor's completed is sampled; no bubble beyond that.
- pc and retired_count update in the cycle after wb_completed, coincident with the next fetch_enabled.
- halt_req arriving in the same cycle as wb_completed counts: the FSM enters HALTED and that instruction is retired.
- Watchdog: with TIMEOUT = N, completed missing for N WAIT cycles → error = 1 in the cycle after the Nth WAIT cycle.
- A completed arriving in the Nth WAIT cycle wins over the timeout.
- Misaligned jump: error = 1 in the cycle after exec_completed; mem_enabled and wb_enabled are never asserted for that instruction.

## Test plan
- Straight-line: rst, start with start_pc = 0x100, stages complete 1 cycle after their enable, need_mem = 0 → fetch_enabled every 8 cycles, pc = 0x100, 0x104, 0x108; retired_count = 3 after the third wb_completed.
- Memory path plus jump: need_mem = 1, exec_is_jump_chosen = 1, exec_jump_dest = 0x200 → mem_enabled asserted exactly once between exec and wb; pc = 0x200 after wb_completed; 10-cycle instruction.
- Halt and restart: halt_req pulsed during EXEC → instruction retires, halted = 1, no further fetch_enabled. Then start with start_pc = 0x40 → pc = 0x40, fetch_enabled the next cycle.
- Watchdog: TIMEOUT = 4, decode_completed never arrives → error = 1, err_cause = 1 after 4 WAIT cycles. A later start and a late decode_completed are both ignored.
- Misaligned jump: exec_jump_dest = 0x202, exec_is_jump_chosen = 1 → err_cause = 2, pc unchanged, retired_count unchanged.
- Reset mid-EXEC: rst for one cycle → all enables 0 and pc = RESET_PC the next cycle. A stale exec_completed arriving after reset causes no state change.
